// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings and default latencies.
// Imported by the MDU, the controller decoder and the hazard unit.
package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  function automatic logic is_mult_op(input mdu_op_e op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational 64-bit result generator for mult/multu/div/divu.
// Produces {hi_n, lo_n} and flags a zero divisor so the caller can suppress the write.
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n,
  output logic        div_zero
);

  logic               ovf_s;
  logic signed [31:0] sa_s;
  logic signed [31:0] sb_s;
  logic signed [31:0] sq_s;
  logic signed [31:0] sr_s;
  logic        [31:0] ub_s;
  logic signed [63:0] sprod_s;
  logic        [63:0] uprod_s;

  // Divisor of 1 covers both /0 (result discarded) and MIN/-1 (quotient is the dividend, rem 0).
  always_comb begin
    div_zero = (in2 == 32'd0);
    ovf_s    = (in1 == 32'h8000_0000) && (in2 == 32'hFFFF_FFFF);
    sa_s     = $signed(in1);
    sb_s     = (div_zero || ovf_s) ? 32'sd1 : $signed(in2);
    ub_s     = div_zero ? 32'd1 : in2;
    sq_s     = sa_s / sb_s;
    sr_s     = sa_s % sb_s;
    sprod_s  = $signed({{32{in1[31]}}, in1}) * $signed({{32{in2[31]}}, in2});
    uprod_s  = {32'd0, in1} * {32'd0, in2};
    hi_n     = 32'd0;
    lo_n     = 32'd0;
    case (op)
      MDU_MULT:  {hi_n, lo_n} = sprod_s;
      MDU_MULTU: {hi_n, lo_n} = uprod_s;
      MDU_DIV: begin
        lo_n = sq_s;
        hi_n = sr_s;
      end
      MDU_DIVU: begin
        lo_n = in1 / ub_s;
        hi_n = in1 % ub_s;
      end
      default: begin
        hi_n = 32'd0;
        lo_n = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu.sv
// EX-stage multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at accept and committed when the latency counter expires.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] In1,
  input  logic [31:0] In2,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  mdu_op_e     op_s;
  logic [31:0] calc_hi_s;
  logic [31:0] calc_lo_s;
  logic        calc_dz_s;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   hi_n_q, hi_n_d;
  logic [31:0]   lo_n_q, lo_n_d;
  logic          dz_q, dz_d;

  assign op_s = mdu_op_e'(MDUOp);

  mdu_calc u_calc (
    .op       (op_s),
    .in1      (In1),
    .in2      (In2),
    .hi_n     (calc_hi_s),
    .lo_n     (calc_lo_s),
    .div_zero (calc_dz_s)
  );

  // Accept, countdown and commit; Start is ignored while a result is in flight.
  always_comb begin
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    hi_n_d = hi_n_q;
    lo_n_d = lo_n_q;
    dz_d   = dz_q;
    if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
      if ((cnt_q == CNT_ONE) && !dz_q) begin
        hi_d = hi_n_q;
        lo_d = lo_n_q;
      end else begin
        hi_d = hi_q;
        lo_d = lo_q;
      end
    end else if (Start) begin
      case (op_s)
        MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
          hi_n_d = calc_hi_s;
          lo_n_d = calc_lo_s;
          dz_d   = is_div_op(op_s) && calc_dz_s;
          cnt_d  = is_mult_op(op_s) ? MULT_LD : DIV_LD;
        end
        MDU_MTHI: hi_d = In1;
        MDU_MTLO: lo_d = In1;
        default:  cnt_d = CNT_ZERO;
      endcase
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= CNT_ZERO;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      hi_n_q <= 32'd0;
      lo_n_q <= 32'd0;
      dz_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      hi_n_q <= hi_n_d;
      lo_n_q <= lo_n_d;
      dz_q   <= dz_d;
    end
  end

  assign Busy = (cnt_q != CNT_ZERO);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed scenarios plus randomized ops against an arithmetic model.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [2:0]  MDUOp = 3'd0;
  logic [31:0] In1 = 32'd0;
  logic [31:0] In2 = 32'd0;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .MDUOp (MDUOp),
    .In1   (In1),
    .In2   (In2),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  // Reference model: plain 64-bit arithmetic on the architectural HI/LO pair.
  task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sp, sa, sb, sq, sr;
    longint unsigned up, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: begin sp = sa * sb; m_hi = sp[63:32]; m_lo = sp[31:0]; end
      3'd2: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      3'd3: if (b != 32'd0) begin sq = sa / sb; sr = sa % sb; m_lo = sq[31:0]; m_hi = sr[31:0]; end
      3'd4: if (b != 32'd0) begin up = ua / ub; m_lo = up[31:0]; up = ua % ub; m_hi = up[31:0]; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic int model_lat(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 5;
    if (op == 3'd3 || op == 3'd4) return 10;
    return 0;
  endfunction

  // Issue one op at a negedge, then count Busy cycles (bounded) and watch HI/LO hold.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output logic held);
    logic [31:0] old_hi, old_lo;
    old_hi = HI;
    old_lo = LO;
    Start = 1'b1; MDUOp = op; In1 = a; In2 = b;
    @(negedge clk);
    Start = 1'b0; MDUOp = 3'd0;
    busy_cycles = 0;
    held = 1'b1;
    while (Busy === 1'b1 && busy_cycles < 50) begin
      if (HI !== old_hi || LO !== old_lo) held = 1'b0;
      busy_cycles++;
      @(negedge clk);
    end
    model_op(op, a, b);
  endtask

  task automatic test_reset();
    int bc; logic held;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    m_hi = 32'd0; m_lo = 32'd0;
    checks++;
    if (HI !== 32'd0 || LO !== 32'd0 || Busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: HI=%h LO=%h Busy=%b, required 0/0/0", HI, LO, Busy);
    end
    run_op(3'd0, 32'hDEAD_BEEF, 32'h1234_5678, bc, held);
    checks++;
    if (bc != 0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL op_none: busy=%0d HI=%h LO=%h, required 0/0/0", bc, HI, LO);
    end
  endtask

  task automatic test_mult();
    int bc; logic held;
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, bc, held);
    checks++;
    if (bc != 5 || held !== 1'b1) begin
      errors++;
      $display("FAIL mult_latency: busy=%0d held=%b, required 5/1", bc, held);
    end
    checks++;
    if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_result: HI=%h LO=%h, required ffffffff/fffffffa", HI, LO);
    end
    run_op(3'd2, 32'hFFFF_FFFE, 32'd3, bc, held);
    checks++;
    if (bc != 5 || held !== 1'b1 || HI !== 32'h0000_0002 || LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL multu: busy=%0d held=%b HI=%h LO=%h, required 5/1/00000002/fffffffa",
               bc, held, HI, LO);
    end
  endtask

  task automatic test_div();
    int bc; logic held;
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, bc, held);
    checks++;
    if (bc != 10 || held !== 1'b1 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_signed: busy=%0d held=%b HI=%h LO=%h, required 10/1/ffffffff/fffffffd",
               bc, held, HI, LO);
    end
    run_op(3'd4, 32'd7, 32'd2, bc, held);
    checks++;
    if (bc != 10 || HI !== 32'd1 || LO !== 32'd3) begin
      errors++;
      $display("FAIL divu: busy=%0d HI=%h LO=%h, required 10/00000001/00000003", bc, HI, LO);
    end
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, bc, held);
    checks++;
    if (bc != 10 || HI !== 32'd0 || LO !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_overflow: busy=%0d HI=%h LO=%h, required 10/00000000/80000000", bc, HI, LO);
    end
  endtask

  task automatic test_mthi_mtlo();
    int bc; logic held; logic busy_seen;
    busy_seen = 1'b0;
    Start = 1'b1; MDUOp = 3'd5; In1 = 32'h1234_5678; In2 = 32'd0;
    @(negedge clk);
    busy_seen = busy_seen | Busy;
    checks++;
    if (HI !== 32'h1234_5678 || LO !== m_lo) begin
      errors++;
      $display("FAIL mthi: HI=%h LO=%h, required 12345678/%h", HI, LO, m_lo);
    end
    MDUOp = 3'd6; In1 = 32'h9ABC_DEF0;
    @(negedge clk);
    busy_seen = busy_seen | Busy;
    Start = 1'b0; MDUOp = 3'd0;
    checks++;
    if (HI !== 32'h1234_5678 || LO !== 32'h9ABC_DEF0 || busy_seen !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: HI=%h LO=%h busy_seen=%b, required 12345678/9abcdef0/0", HI, LO, busy_seen);
    end
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
    run_op(3'd4, 32'h5555_5555, 32'd0, bc, held);
    checks++;
    if (bc != 10 || held !== 1'b1 || HI !== 32'h1234_5678 || LO !== 32'h9ABC_DEF0) begin
      errors++;
      $display("FAIL div_by_zero: busy=%0d held=%b HI=%h LO=%h, required 10/1/12345678/9abcdef0",
               bc, held, HI, LO);
    end
  endtask

  task automatic test_busy_ignore();
    int bc; logic stray;
    Start = 1'b1; MDUOp = 3'd4; In1 = 32'd100; In2 = 32'd7;
    @(negedge clk);
    Start = 1'b0; MDUOp = 3'd0;
    bc = 0;
    while (Busy === 1'b1 && bc < 50) begin
      bc++;
      if (bc == 3) begin
        Start = 1'b1; MDUOp = 3'd1; In1 = 32'hFFFF_FFFF; In2 = 32'h7FFF_FFFF;
      end else begin
        Start = 1'b0; MDUOp = 3'd0;
      end
      @(negedge clk);
    end
    Start = 1'b0; MDUOp = 3'd0;
    model_op(3'd4, 32'd100, 32'd7);
    checks++;
    if (bc != 10 || HI !== 32'd2 || LO !== 32'd14) begin
      errors++;
      $display("FAIL busy_ignore: busy=%0d HI=%h LO=%h, required 10/00000002/0000000e", bc, HI, LO);
    end
    stray = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (Busy !== 1'b0 || HI !== 32'd2 || LO !== 32'd14) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL busy_ignore_stray: late change seen, Busy=%b HI=%h LO=%h", Busy, HI, LO);
    end
  endtask

  task automatic test_reset_midop();
    logic stray;
    Start = 1'b1; MDUOp = 3'd1; In1 = 32'd1234; In2 = 32'd5678;
    @(negedge clk);
    Start = 1'b0; MDUOp = 3'd0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    checks++;
    if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_midop: Busy=%b HI=%h LO=%h, required 0/0/0", Busy, HI, LO);
    end
    stray = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop_late: late write seen, Busy=%b HI=%h LO=%h", Busy, HI, LO);
    end
  endtask

  task automatic test_random();
    int bc; logic held; logic [2:0] op; logic [31:0] a, b;
    logic [31:0] specials [4];
    specials[0] = 32'h0000_0000; specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h8000_0000; specials[3] = 32'h7FFF_FFFF;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
      b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
      run_op(op, a, b, bc, held);
      checks++;
      if (bc != model_lat(op) || held !== 1'b1 || HI !== m_hi || LO !== m_lo) begin
        errors++;
        $display("FAIL random_op%0d: op=%0d a=%h b=%h busy=%0d held=%b HI=%h LO=%h, required busy=%0d HI=%h LO=%h",
                 i, op, a, b, bc, held, HI, LO, model_lat(op), m_hi, m_lo);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_reset_midop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
